// File: rtl/spdif_rx_ctrl_if.sv
// Downstream frame handshake between the S/PDIF sequencing controller and the mixer.
interface spdif_rx_ctrl_if;
    logic [23:0] data_l_o;
    logic [23:0] data_r_o;
    logic        valid_o;
    logic        ready_i;

    modport master (output data_l_o, output data_r_o, output valid_o, input ready_i);
    modport slave  (input data_l_o, input data_r_o, input valid_o, output ready_i);
endinterface

// File: rtl/spdif_rx_ctrl.sv
// S/PDIF receive sequencer: pairs L/R subframes, qualifies them against lock
// and an acquisition run of clean pairs, holds one stereo frame for the mixer,
// and tracks the channel-status sample-rate code.
module spdif_rx_ctrl #(
    parameter int ACQ_PAIRS      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_LOG2   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [23:0]            dai_data_i,
    input  logic                   dai_ack_i,
    input  logic                   dai_lrck_i,
    input  logic                   dai_locked_i,
    input  logic [191:0]           dai_cdata_i,
    spdif_rx_ctrl_if.master        out_if,
    output logic [1:0]             state_o,
    output logic [3:0]             rate_o,
    output logic                   rate_valid_o,
    output logic                   rate_change_o,
    output logic                   overrun_o
);
    localparam int ACQ_W = $clog2(ACQ_PAIRS + 1);
    localparam logic [TIMEOUT_LOG2-1:0] WD_LAST = TIMEOUT_LOG2'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    pend_q, pend_d;
    logic [23:0]             left_q, left_d;
    logic [ACQ_W-1:0]        acq_q, acq_d;
    logic [TIMEOUT_LOG2-1:0] wdog_q, wdog_d;
    logic [23:0]             dl_q, dl_d, dr_q, dr_d;
    logic                    valid_q, valid_d;
    logic [3:0]              rate_q, rate_d;
    logic                    rvld_q, rvld_d;
    logic                    rchg_q, rchg_d;
    logic                    ovr_q, ovr_d;
    logic                    pair_ok, pair_err;
    logic                    timeout;
    logic [3:0]              cs_rate;
    logic                    unused_cdata;

    // Rate code lives in CS bits 27..24; CS bit k sits at dai_cdata_i[191-k].
    assign cs_rate      = {dai_cdata_i[164], dai_cdata_i[165], dai_cdata_i[166], dai_cdata_i[167]};
    assign unused_cdata = ^{dai_cdata_i[191:168], dai_cdata_i[163:0]};
    assign timeout      = (state_q != UNLOCKED) && (wdog_q == WD_LAST);

    // Next-state: lock/watchdog first, then the subframe is judged in the resulting state.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        left_d   = left_q;
        acq_d    = acq_q;
        wdog_d   = wdog_q;
        dl_d     = dl_q;
        dr_d     = dr_q;
        valid_d  = valid_q;
        rate_d   = rate_q;
        rvld_d   = rvld_q;
        rchg_d   = 1'b0;
        ovr_d    = 1'b0;
        pair_ok  = 1'b0;
        pair_err = 1'b0;

        case (state_q)
            UNLOCKED: begin
                if (dai_locked_i) begin
                    state_d = ACQUIRE;
                    pend_d  = 1'b0;
                    acq_d   = '0;
                end
            end
            default: begin
                if (!dai_locked_i || timeout) state_d = UNLOCKED;
            end
        endcase

        // A subframe arriving as the link drops is ignored.
        if (dai_ack_i && state_d != UNLOCKED) begin
            if (!dai_lrck_i) begin
                pair_err = pend_d;
                pend_d   = 1'b1;
                left_d   = dai_data_i;
            end else if (pend_d) begin
                pair_ok = 1'b1;
                pend_d  = 1'b0;
            end else begin
                pair_err = 1'b1;
            end
        end

        // Downstream accept frees the slot; a load below may refill it.
        if (valid_q && out_if.ready_i) valid_d = 1'b0;

        if (state_d == ACQUIRE) begin
            if (pair_err) begin
                acq_d = '0;
            end else if (pair_ok) begin
                acq_d = acq_d + 1'b1;
                if (acq_d == ACQ_W'(ACQ_PAIRS)) begin
                    // The qualifying pair is consumed, not emitted.
                    state_d = RUN;
                    rvld_d  = 1'b0;
                end
            end
        end else if (state_d == RUN) begin
            if (pair_err) begin
                // Held frame stays for the mixer; only sequencing restarts.
                state_d = ACQUIRE;
                acq_d   = '0;
                pend_d  = 1'b0;
            end else if (pair_ok) begin
                rate_d = cs_rate;
                rvld_d = 1'b1;
                rchg_d = rvld_q && (cs_rate != rate_q);
                if (!valid_q || out_if.ready_i) begin
                    valid_d = 1'b1;
                    dl_d    = left_q;
                    dr_d    = dai_data_i;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end else begin
            valid_d = 1'b0;
            rvld_d  = 1'b0;
        end

        if (state_d == UNLOCKED || dai_ack_i) wdog_d = '0;
        else if (wdog_q != '1)                wdog_d = wdog_q + 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
            pend_q  <= 1'b0;
            left_q  <= '0;
            acq_q   <= '0;
            wdog_q  <= '0;
            dl_q    <= '0;
            dr_q    <= '0;
            valid_q <= 1'b0;
            rate_q  <= '0;
            rvld_q  <= 1'b0;
            rchg_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            left_q  <= left_d;
            acq_q   <= acq_d;
            wdog_q  <= wdog_d;
            dl_q    <= dl_d;
            dr_q    <= dr_d;
            valid_q <= valid_d;
            rate_q  <= rate_d;
            rvld_q  <= rvld_d;
            rchg_q  <= rchg_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_if.data_l_o = dl_q;
    assign out_if.data_r_o = dr_q;
    assign out_if.valid_o  = valid_q;
    assign state_o         = state_q;
    assign rate_o          = rate_q;
    assign rate_valid_o    = rvld_q;
    assign rate_change_o   = rchg_q;
    assign overrun_o       = ovr_q;
endmodule

// File: tb/tb_spdif_rx_ctrl.sv
// Bench for spdif_rx_ctrl: directed scenarios plus random traffic, checked by a
// behavioural model feeding frame/rate-change scoreboards and a per-cycle status check.
module tb_spdif_rx_ctrl;
    localparam int TO  = 1024;
    localparam int ACQ = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [23:0]  data;
    logic         ack, lrck, locked;
    logic [191:0] cdata;
    logic [1:0]   state;
    logic [3:0]   rate;
    logic         rate_valid, rate_change, overrun;

    spdif_rx_ctrl_if bus();

    spdif_rx_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .dai_data_i(data), .dai_ack_i(ack), .dai_lrck_i(lrck),
        .dai_locked_i(locked), .dai_cdata_i(cdata),
        .out_if(bus),
        .state_o(state), .rate_o(rate), .rate_valid_o(rate_valid),
        .rate_change_o(rate_change), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [47:0] exp_q[$];     // frames the mixer should receive, in order
    logic [3:0]  rchg_q[$];    // rate codes that should be announced by a change pulse
    int          exp_ovr = 0;
    int          act_ovr = 0;

    int          m_mode;       // 0 unlocked, 1 acquiring, 2 running
    bit          m_pend;
    logic [23:0] m_left;
    int          m_good;
    int          m_idle;
    bit          m_have;
    logic [23:0] m_hl, m_hr;
    logic [3:0]  m_rate;
    bit          m_rate_seen;

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_left = '0; m_good = 0; m_idle = 0;
        m_have = 0; m_hl = '0; m_hr = '0; m_rate = '0; m_rate_seen = 0;
    endtask

    task automatic model_step();
        bit pair, perr, timed_out;
        int nxt;
        logic [3:0] r;
        r = {cdata[191-27], cdata[191-26], cdata[191-25], cdata[191-24]};
        if (m_have && bus.ready_i) begin
            exp_q.push_back({m_hl, m_hr});
            m_have = 0;
        end
        timed_out = (m_mode != 0) && (m_idle == TO - 1);
        nxt = m_mode;
        if (m_mode == 0) begin
            if (locked) begin nxt = 1; m_pend = 0; m_good = 0; end
        end else if (!locked || timed_out) begin
            nxt = 0;
        end
        pair = 0; perr = 0;
        if (ack && nxt != 0) begin
            if (!lrck) begin perr = m_pend; m_pend = 1; m_left = data; end
            else if (m_pend) begin pair = 1; m_pend = 0; end
            else perr = 1;
        end
        if (nxt == 1) begin
            if (perr) m_good = 0;
            else if (pair) begin
                m_good++;
                if (m_good == ACQ) begin nxt = 2; m_rate_seen = 0; end
            end
        end else if (nxt == 2) begin
            if (perr) begin nxt = 1; m_good = 0; m_pend = 0; end
            else if (pair) begin
                if (m_rate_seen && r != m_rate) rchg_q.push_back(r);
                m_rate = r; m_rate_seen = 1;
                if (!m_have) begin m_have = 1; m_hl = m_left; m_hr = data; end
                else exp_ovr++;
            end
        end else begin
            m_have = 0; m_rate_seen = 0;
        end
        if (nxt == 0 || ack) m_idle = 0;
        else if (m_idle < TO - 1) m_idle++;
        m_mode = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit          acc_pend;
        logic [47:0] acc_f;
        acc_pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_pend = 0;
            end else begin
                if (acc_pend) begin
                    chk("frame_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) chk("frame_data", 64'(acc_f), 64'(exp_q.pop_front()));
                    acc_pend = 0;
                end
                chk("status", 64'({state, bus.valid_o, rate_valid, rate}),
                    64'({2'(m_mode), m_have, m_rate_seen, m_rate}));
                if (bus.valid_o && bus.ready_i) begin
                    acc_pend = 1;
                    acc_f    = {bus.data_l_o, bus.data_r_o};
                end
                if (rate_change) begin
                    chk("rchg_expected", 64'(rchg_q.size() != 0), 64'(1));
                    if (rchg_q.size() != 0) chk("rchg_rate", 64'(rate), 64'(rchg_q.pop_front()));
                end
                if (overrun) act_ovr++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1; ack = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) cyc();
    endtask
    task automatic send(input bit lr, input logic [23:0] d);
        ack = 1'b1; lrck = lr; data = d; cyc();
    endtask
    task automatic pair(input logic [23:0] l, input logic [23:0] r);
        send(1'b0, l); send(1'b1, r);
    endtask
    task automatic clean_pairs(input int n);
        for (int k = 0; k < n; k++) pair(24'($urandom), 24'($urandom));
    endtask
    task automatic set_cs_rate(input bit b24, input bit b25, input bit b26, input bit b27);
        cdata[191-24] = b24; cdata[191-25] = b25; cdata[191-26] = b26; cdata[191-27] = b27;
    endtask

    initial begin
        bit next_lr;
        rst_n = 1'b0; ack = 1'b0; lrck = 1'b0; locked = 1'b0; data = '0;
        cdata = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        bus.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({state, bus.valid_o, bus.data_l_o, bus.data_r_o, rate, rate_valid, rate_change, overrun}), 64'(0));
        rst_n = 1'b1;
        cyc();
        chk("unlocked_idle", 64'(state), 64'(0));

        // Acquisition: four clean pairs reach RUN, nothing emitted.
        locked = 1'b1;
        set_cs_rate(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("enter_acquire", 64'(state), 64'(1));
        clean_pairs(3);
        chk("acq_3_pairs", 64'(state), 64'(1));
        clean_pairs(1);
        chk("acq_4_pairs_run", 64'(state), 64'(2));
        chk("acq_no_frame", 64'(bus.valid_o), 64'(0));

        // First RUN frame and first rate capture.
        pair(24'h123456, 24'hABCDEF);
        chk("frame1_valid", 64'(bus.valid_o), 64'(1));
        chk("frame1_l", 64'(bus.data_l_o), 64'(24'h123456));
        chk("frame1_r", 64'(bus.data_r_o), 64'(24'hABCDEF));
        chk("rate_first", 64'({rate_valid, rate, rate_change}), 64'({1'b1, 4'b0010, 1'b0}));

        // Overrun while stalled, with a rate change on the dropped pair.
        set_cs_rate(1'b1, 1'b1, 1'b0, 1'b0);
        pair(24'h111111, 24'h222222);
        chk("overrun_pulse", 64'(overrun), 64'(1));
        chk("overrun_hold", 64'({bus.data_l_o, bus.data_r_o}), 64'({24'h123456, 24'hABCDEF}));
        chk("rate_change", 64'({rate, rate_change}), 64'({4'b0011, 1'b1}));
        cyc();
        chk("pulses_single", 64'({overrun, rate_change}), 64'(0));

        // Accept and load on the same edge.
        send(1'b0, 24'h333333);
        bus.ready_i = 1'b1;
        send(1'b1, 24'h444444);
        chk("acc_load_valid", 64'(bus.valid_o), 64'(1));
        chk("acc_load_data", 64'({bus.data_l_o, bus.data_r_o}), 64'({24'h333333, 24'h444444}));
        cyc();
        chk("accept_clears", 64'(bus.valid_o), 64'(0));

        // L,L,R in RUN drops back to ACQUIRE; four clean pairs return to RUN.
        send(1'b0, 24'hAAAAAA);
        send(1'b0, 24'hBBBBBB);
        chk("pair_err_acq", 64'(state), 64'(1));
        send(1'b1, 24'hCCCCCC);
        chk("pair_err_no_frame", 64'({state, bus.valid_o}), 64'({2'd1, 1'b0}));
        clean_pairs(4);
        chk("reacquire_run", 64'({state, bus.valid_o}), 64'({2'd2, 1'b0}));

        // Watchdog: hold a frame, then starve the link.
        bus.ready_i = 1'b0;
        pair(24'h5A5A5A, 24'hA5A5A5);
        chk("wd_frame_held", 64'(bus.valid_o), 64'(1));
        idle(TO - 1);
        chk("wd_not_yet", 64'(state), 64'(2));
        idle(1);
        chk("wd_timeout", 64'({state, bus.valid_o, rate_valid}), 64'(0));
        chk("wd_data_hold", 64'(bus.data_l_o), 64'(24'h5A5A5A));

        // Lock loss mid-ACQUIRE.
        cyc();
        chk("relock_acq", 64'(state), 64'(1));
        clean_pairs(2);
        locked = 1'b0;
        cyc();
        chk("lock_loss", 64'(state), 64'(0));

        // Asynchronous reset in RUN with a held frame.
        locked = 1'b1;
        cyc();
        clean_pairs(4);
        pair(24'h0F0F0F, 24'hF0F0F0);
        chk("pre_reset_valid", 64'({state, bus.valid_o}), 64'({2'd2, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({state, bus.valid_o, bus.data_l_o, bus.data_r_o, rate, rate_valid, rate_change, overrun}), 64'(0));
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        #1;
        chk("post_reset_state", 64'(state), 64'(0));

        // Random traffic.
        next_lr = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            bus.ready_i = ($urandom_range(0, 3) != 0);
            locked      = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) < 4)
                set_cs_rate(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 1200) idle(TO + 6);
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 99) < 5) next_lr = ~next_lr;
            send(next_lr, 24'($urandom));
            next_lr = ~next_lr;
        end

        bus.ready_i = 1'b1;
        idle(3);
        bus.ready_i = 1'b0;
        idle(3);
        chk("frames_drained", 64'(exp_q.size()), 64'(0));
        chk("rchg_drained", 64'(rchg_q.size()), 64'(0));
        chk("overrun_count", 64'(act_ovr), 64'(exp_ovr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
